// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory through a
// request/valid handshake and hands each instruction to the control unit.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        pc_2_en,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    output logic [15:0] instruction,
    output logic        inst_load,
    output logic [15:0] pc,
    output logic        align_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUED = 2'd2
    } state_t;

    state_t state;

    function automatic logic [15:0] pc_plus_2(input logic [15:0] cur);
        return cur + 16'd2;
    endfunction

    // Request is decoded from the state register, so reset drops it at once.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= 16'h0000;
            inst_load   <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            inst_load <= 1'b0;
            align_err <= 1'b0;
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_valid) begin
                        instruction <= imem_rdata;
                        inst_load   <= 1'b1;
                        state       <= ISSUED;
                    end
                end
                ISSUED: begin
                    // Branch beats sequential advance; an odd target is realigned and flagged.
                    if (branch_en) begin
                        pc        <= {branch_target[15:1], 1'b0};
                        align_err <= branch_target[0];
                        state     <= FETCH;
                    end else if (pc_2_en) begin
                        pc    <= pc_plus_2(pc);
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
